// File: rtl/stdp_synapse.sv
// Plastic synapse with pair-based STDP learning and a registered current output.
// Optional weight decay toward W_INIT is enabled by defining STDP_DECAY_EN.
module stdp_synapse #(
  parameter int WEIGHT_W  = 8,
  parameter int DT_W      = 4,
  parameter int WINDOW    = 8,
  parameter int W_INIT    = 16,
  parameter int W_MAX     = 255,
  parameter int A_PLUS    = 16,
  parameter int A_MINUS   = 16,
  parameter int DECAY_PER = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pre_spike,
  input  logic                post_spike,
  output logic [WEIGHT_W-1:0] syn_current,
  output logic [WEIGHT_W-1:0] weight,
  output logic                update_w_flag,
  output logic                ltp,
  output logic [DT_W-1:0]     time_diff
);

  localparam logic [DT_W-1:0]     WinT   = DT_W'(WINDOW);
  localparam logic [WEIGHT_W-1:0] WInit  = WEIGHT_W'(W_INIT);
  localparam logic [WEIGHT_W:0]   WMaxX  = (WEIGHT_W + 1)'(W_MAX);
  localparam logic [WEIGHT_W-1:0] APlus  = WEIGHT_W'(A_PLUS);
  localparam logic [WEIGHT_W-1:0] AMinus = WEIGHT_W'(A_MINUS);

  logic [DT_W-1:0]     pre_t, post_t;
  logic                pre_v, post_v;
  logic                pair_ltp, pair_ltd;
  logic [DT_W-1:0]     dt_sel;
  logic [WEIGHT_W-1:0] delta;

  logic                s1_v, s1_ltp;
  logic [WEIGHT_W-1:0] s1_delta;
  logic [DT_W-1:0]     s1_dt;

  logic [WEIGHT_W:0]   w_sum, w_diff;
  logic [WEIGHT_W-1:0] w_stdp;
  logic                decay_tick;
  logic [WEIGHT_W-1:0] w_decay;

  // Pair detection: a simultaneous pre+post never pairs
  always_comb begin
    pair_ltp = post_spike && !pre_spike && pre_v;
    pair_ltd = pre_spike && !post_spike && post_v;
    dt_sel   = pair_ltp ? pre_t : post_t;
    delta    = (pair_ltp ? APlus : AMinus) >> (dt_sel - 1'b1);
  end

  // Presynaptic interval timer; loads 1 so a pair one cycle later sees dt=1
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_t <= '0;
      pre_v <= 1'b0;
    end else if (pre_spike) begin
      pre_t <= DT_W'(1);
      pre_v <= 1'b1;
    end else begin
      if (pre_t < WinT) pre_t <= pre_t + 1'b1;
      if (pair_ltp || pre_t >= WinT - 1'b1) pre_v <= 1'b0;
    end
  end

  // Postsynaptic interval timer, mirror of the presynaptic one
  always_ff @(posedge clk) begin
    if (rst) begin
      post_t <= '0;
      post_v <= 1'b0;
    end else if (post_spike) begin
      post_t <= DT_W'(1);
      post_v <= 1'b1;
    end else begin
      if (post_t < WinT) post_t <= post_t + 1'b1;
      if (pair_ltd || post_t >= WinT - 1'b1) post_v <= 1'b0;
    end
  end

  // Stage 1: capture direction, amplitude and interval of the detected pair
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_ltp   <= 1'b0;
      s1_delta <= '0;
      s1_dt    <= '0;
    end else begin
      s1_v     <= pair_ltp || pair_ltd;
      s1_ltp   <= pair_ltp;
      s1_delta <= delta;
      s1_dt    <= dt_sel;
    end
  end

  // Saturating weight arithmetic in one extra bit
  always_comb begin
    w_sum  = {1'b0, weight} + {1'b0, s1_delta};
    w_diff = {1'b0, weight} - {1'b0, s1_delta};
    if (s1_ltp) w_stdp = (w_sum > WMaxX) ? WMaxX[WEIGHT_W-1:0] : w_sum[WEIGHT_W-1:0];
    else        w_stdp = w_diff[WEIGHT_W] ? '0 : w_diff[WEIGHT_W-1:0];
  end

`ifdef STDP_DECAY_EN
  localparam int CntW = $clog2(DECAY_PER + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DECAY_PER - 1);
  logic [CntW-1:0] decay_cnt;

  // Decay period counter; any STDP write restarts the period
  always_ff @(posedge clk) begin
    if (rst || s1_v || decay_cnt == CntLast) decay_cnt <= '0;
    else                                      decay_cnt <= decay_cnt + 1'b1;
  end

  // One unit step toward the initial weight
  always_comb begin
    decay_tick = (decay_cnt == CntLast);
    if (weight > WInit)      w_decay = weight - 1'b1;
    else if (weight < WInit) w_decay = weight + 1'b1;
    else                     w_decay = weight;
  end
`else
  // No decay in this build: weight moves only by STDP or reset
  always_comb begin
    decay_tick = 1'b0;
    w_decay    = weight;
  end
`endif

  // Stage 2: write the weight and publish the update report
  always_ff @(posedge clk) begin
    if (rst) begin
      weight        <= WInit;
      update_w_flag <= 1'b0;
      ltp           <= 1'b0;
      time_diff     <= '0;
    end else begin
      update_w_flag <= s1_v;
      if (s1_v) begin
        weight    <= w_stdp;
        ltp       <= s1_ltp;
        time_diff <= s1_dt;
      end else if (decay_tick) begin
        weight <= w_decay;
      end
    end
  end

  // Current uses the weight present in the spike cycle
  always_ff @(posedge clk) begin
    if (rst) syn_current <= '0;
    else     syn_current <= pre_spike ? weight : '0;
  end

endmodule

// File: tb/tb_stdp_synapse.sv
// Bench for stdp_synapse: timestamp-based reference model plus directed literal checks.
module tb_stdp_synapse;
  localparam int WINDOW  = 8;
  localparam int W_INIT  = 16;
  localparam int W_MAX   = 255;
  localparam int A_PLUS  = 16;
  localparam int A_MINUS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pre_spike = 1'b0;
  logic       post_spike = 1'b0;
  logic [7:0] syn_current, weight;
  logic       update_w_flag, ltp;
  logic [3:0] time_diff;

  int n_tests = 0;
  int n_fail  = 0;

  stdp_synapse dut (
    .clk          (clk),
    .rst          (rst),
    .pre_spike    (pre_spike),
    .post_spike   (post_spike),
    .syn_current  (syn_current),
    .weight       (weight),
    .update_w_flag(update_w_flag),
    .ltp          (ltp),
    .time_diff    (time_diff)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works from spike timestamps and a queue of scheduled updates
  typedef struct {int due; bit dir; int dt;} pend_t;
  pend_t pend[$];
  int  cyc = 0;
  int  last_pre, last_post;
  bit  pre_ok, post_ok;
  int  m_w, m_cur, m_td;
  bit  m_flag, m_ltp;
  bit  mdl_on = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_w = W_INIT; m_cur = 0; m_flag = 0; m_ltp = 0; m_td = 0;
      pre_ok = 0; post_ok = 0;
      pend.delete();
      mdl_on = 1;
    end else begin
      m_cur  = pre_spike ? m_w : 0;
      m_flag = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        int d;
        d = (pend[0].dir ? A_PLUS : A_MINUS) / (1 << (pend[0].dt - 1));
        if (pend[0].dir) m_w = (m_w + d > W_MAX) ? W_MAX : m_w + d;
        else             m_w = (m_w - d < 0) ? 0 : m_w - d;
        m_flag = 1; m_ltp = pend[0].dir; m_td = pend[0].dt;
        void'(pend.pop_front());
      end
      if (pre_spike && post_spike) begin
        last_pre = cyc; last_post = cyc; pre_ok = 1; post_ok = 1;
      end else if (post_spike) begin
        if (pre_ok && cyc - last_pre < WINDOW) begin
          pend.push_back('{due: cyc + 1, dir: 1'b1, dt: cyc - last_pre});
          pre_ok = 0;
        end
        last_post = cyc; post_ok = 1;
      end else if (pre_spike) begin
        if (post_ok && cyc - last_post < WINDOW) begin
          pend.push_back('{due: cyc + 1, dir: 1'b0, dt: cyc - last_post});
          post_ok = 0;
        end
        last_pre = cyc; pre_ok = 1;
      end
    end
    cyc++;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (mdl_on) begin
      check("weight", weight, m_w);
      check("syn_current", syn_current, m_cur);
      check("update_w_flag", update_w_flag, m_flag);
      check("ltp", ltp, m_ltp);
      check("time_diff", time_diff, m_td);
    end
  end

  // Drive one cycle worth of inputs, then move just past the next rising edge
  task automatic step(input logic p, input logic q, input logic r);
    pre_spike = p; post_spike = q; rst = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step(0, 0, 1); step(0, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  // Ends in the cycle where the update is visible (spike cycle + 2)
  task automatic ltp_pair(input int dt);
    step(1, 0, 0);
    repeat (dt - 1) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic ltd_pair(input int dt);
    step(0, 1, 0);
    repeat (dt - 1) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    check("rst_weight", weight, 16);
    check("rst_cur", syn_current, 0);
    check("rst_flag", update_w_flag, 0);
    check("rst_td", time_diff, 0);

    ltp_pair(2);
    check("ltp_weight", weight, 24);
    check("ltp_model", m_w, 24);
    check("ltp_flag", update_w_flag, 1);
    check("ltp_dir", ltp, 1);
    check("ltp_td", time_diff, 2);
    idle(10);

    do_reset();
    ltd_pair(3);
    check("ltd_weight", weight, 12);
    check("ltd_model", m_w, 12);
    check("ltd_flag", update_w_flag, 1);
    check("ltd_dir", ltp, 0);
    check("ltd_td", time_diff, 3);
    idle(10);

    do_reset();
    step(1, 0, 0);
    idle(7);
    step(0, 1, 0);
    idle(2);
    check("window_flag", update_w_flag, 0);
    check("window_weight", weight, 16);
    idle(10);

    do_reset();
    step(1, 1, 0);
    step(0, 1, 0);
    check("simul_flag", update_w_flag, 0);
    step(0, 0, 0);
    check("simul_weight", weight, 32);
    check("simul_flag2", update_w_flag, 1);
    check("simul_td", time_diff, 1);
    idle(10);

    do_reset();
    step(1, 0, 0);
    check("cur_on", syn_current, 16);
    step(0, 0, 0);
    check("cur_off", syn_current, 0);
    idle(10);

    do_reset();
    repeat (14) begin ltp_pair(1); idle(10); end
    ltp_pair(2); idle(10);
    ltp_pair(4);
    check("sat_pre", weight, 250);
    idle(10);
    ltp_pair(1);
    check("sat_hi", weight, 255);
    check("sat_hi_model", m_w, 255);
    idle(10);

    do_reset();
    ltd_pair(2); idle(10);
    ltd_pair(3); idle(10);
    ltd_pair(5);
    check("sat_lo_pre", weight, 3);
    idle(10);
    ltd_pair(1);
    check("sat_lo", weight, 0);
    check("sat_lo_model", m_w, 0);
    idle(10);

    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    check("midrst_weight", weight, 16);
    check("midrst_flag", update_w_flag, 0);
    step(0, 0, 0);
    check("midrst_flag2", update_w_flag, 0);
    check("midrst_weight2", weight, 16);
    idle(10);

    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    check("b2b_w1", weight, 32);
    check("b2b_ltp1", ltp, 1);
    check("b2b_cur", syn_current, 16);
    step(0, 0, 0);
    check("b2b_w2", weight, 16);
    check("b2b_ltp2", ltp, 0);
    check("b2b_flag2", update_w_flag, 1);
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
